// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_engine
// Brief    : Memory-to-memory word copier with running 16-bit checksum,
//            acting as a second master on the 4K x 16 data memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAdr,
  input  logic [ADDR_W-1:0] dstAdr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] writeData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] readData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_i;
  logic [DATA_W-1:0]  r_buf;
  logic [DATA_W-1:0]  r_checksum;
  logic [LEN_W-1:0]   w_iNext;
  logic               w_lastWord;
  logic [ADDR_W-1:0]  w_srcAdrCur;
  logic [ADDR_W-1:0]  w_dstAdrCur;

  // Counter is one bit wider than the address so len=4096 terminates;
  // the address sums drop that bit and wrap modulo the memory size.
  assign w_iNext     = r_i + LEN_W'(1);
  assign w_lastWord  = (w_iNext == r_len);
  assign w_srcAdrCur = r_src + r_i[ADDR_W-1:0];
  assign w_dstAdrCur = r_dst + r_i[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_i        <= '0;
      r_buf      <= '0;
      r_checksum <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src      <= srcAdr;
            r_dst      <= dstAdr;
            r_len      <= len;
            r_i        <= '0;
            r_checksum <= '0;
          end
        end
        READ: begin
          r_buf      <= readData;
          r_checksum <= r_checksum + readData;
        end
        WRITE: begin
          r_i <= w_iNext;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so start never reaches the bus.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    memAdr      = '0;
    writeData   = '0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy        = 1'b1;
        memAdr      = w_srcAdrCur;
        memRead     = 1'b1;
        w_nextState = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        memAdr      = w_dstAdrCur;
        writeData   = r_buf;
        memWrite    = 1'b1;
        w_nextState = w_lastWord ? DONE : READ;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign checksum = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_engine
// Brief    : Directed self-checking bench for mem_copy_engine with a 4K x 16
//            behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] srcAdr;
  logic [11:0] dstAdr;
  logic [12:0] len;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [11:0] memAdr;
  logic [15:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [15:0] readData;

  logic [15:0] mem [0:4095];
  logic        tbWe;
  logic [11:0] tbAdr;
  logic [15:0] tbData;

  int nVec  = 0;
  int nFail = 0;

  int busyCnt, doneCnt, doneAt, bothHigh, rdCnt, wrCnt;
  logic [11:0] readAdrs [$];

  mem_copy_engine #(.ADDR_W(12), .DATA_W(16), .LEN_W(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .srcAdr    (srcAdr),
    .dstAdr    (dstAdr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .memAdr    (memAdr),
    .writeData (writeData),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .readData  (readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWrite) mem[memAdr] <= writeData;
    else if (tbWe) mem[tbAdr] <= tbData;
  end
  assign readData = memRead ? mem[memAdr] : 16'h0000;

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    tbWe = 1'b1; tbAdr = a; tbData = d;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  // Launch a copy and observe it until one cycle past done; optional
  // junk start pulse at cycle interfereAt (0 = none).
  task automatic do_copy(input logic [11:0] s, input logic [11:0] d,
                         input logic [12:0] n, input int interfereAt);
    @(negedge clk);
    srcAdr = s; dstAdr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCnt = 0; doneCnt = 0; doneAt = -1; bothHigh = 0; rdCnt = 0; wrCnt = 0;
    readAdrs.delete();
    for (int c = 1; c <= 20000; c++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = c;
      end
      if (memRead && memWrite) bothHigh++;
      if (memRead) begin rdCnt++; readAdrs.push_back(memAdr); end
      if (memWrite) wrCnt++;
      if (doneAt >= 0 && c > doneAt) break;
      if (c == interfereAt) begin
        srcAdr = 12'h000; dstAdr = 12'h000; len = 13'd1; start = 1'b1;
      end else begin
        start = 1'b0;
        if (interfereAt != 0 && c == interfereAt + 1) srcAdr = 12'hABC;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; srcAdr = '0; dstAdr = '0; len = '0; tbWe = 1'b0;
    tbAdr = '0; tbData = '0;
    repeat (3) @(negedge clk);
    nVec++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nVec++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b expected 0", done); end
    nVec++; if (checksum !== 16'h0) begin nFail++; $display("FAIL reset_checksum: got %h expected 0000", checksum); end
    nVec++; if (memAdr !== 12'h0) begin nFail++; $display("FAIL reset_memAdr: got %h expected 000", memAdr); end
    nVec++; if (writeData !== 16'h0) begin nFail++; $display("FAIL reset_writeData: got %h expected 0000", writeData); end
    nVec++; if ({memRead, memWrite} !== 2'b00) begin nFail++; $display("FAIL reset_enables: got %b expected 00", {memRead, memWrite}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    poke(12'h010, 16'h0001); poke(12'h011, 16'h0002);
    poke(12'h012, 16'h0003); poke(12'h013, 16'h0004);
    do_copy(12'h010, 12'h200, 13'd4, 0);
    for (int k = 0; k < 4; k++) begin
      nVec++;
      if (mem[12'h200 + k] !== 16'(k + 1)) begin nFail++;
        $display("FAIL basic_data[%0d]: got %h expected %h", k, mem[12'h200 + k], 16'(k + 1)); end
    end
    nVec++; if (busyCnt != 8) begin nFail++; $display("FAIL basic_busy_cycles: got %0d expected 8", busyCnt); end
    nVec++; if (doneCnt != 1) begin nFail++; $display("FAIL basic_done_cycles: got %0d expected 1", doneCnt); end
    nVec++; if (doneAt != 9) begin nFail++; $display("FAIL basic_done_at: got %0d expected 9", doneAt); end
    nVec++; if (checksum !== 16'h000A) begin nFail++; $display("FAIL basic_checksum: got %h expected 000a", checksum); end
    nVec++; if (bothHigh != 0) begin nFail++; $display("FAIL basic_both_enables: got %0d expected 0", bothHigh); end
    nVec++; if (readAdrs.size() != 4 || readAdrs[0] !== 12'h010 || readAdrs[3] !== 12'h013) begin nFail++;
      $display("FAIL basic_read_order: got %0d reads expected 4 from 010..013", readAdrs.size()); end
    nVec++; if (busy !== 1'b0 || memAdr !== 12'h0) begin nFail++;
      $display("FAIL basic_idle_after: got busy=%b memAdr=%h expected 0/000", busy, memAdr); end
  endtask

  task automatic test_len0;
    do_copy(12'h020, 12'h300, 13'd0, 0);
    nVec++; if (doneAt != 1) begin nFail++; $display("FAIL len0_done_at: got %0d expected 1", doneAt); end
    nVec++; if (doneCnt != 1) begin nFail++; $display("FAIL len0_done_cycles: got %0d expected 1", doneCnt); end
    nVec++; if (busyCnt != 0 || rdCnt != 0 || wrCnt != 0) begin nFail++;
      $display("FAIL len0_activity: got busy=%0d rd=%0d wr=%0d expected 0/0/0", busyCnt, rdCnt, wrCnt); end
    nVec++; if (checksum !== 16'h0000) begin nFail++; $display("FAIL len0_checksum: got %h expected 0000", checksum); end
  endtask

  task automatic test_wrap;
    poke(12'hFFE, 16'hAAAA); poke(12'hFFF, 16'h5555); poke(12'h000, 16'h1111);
    do_copy(12'hFFE, 12'h100, 13'd3, 0);
    nVec++; if (readAdrs.size() != 3 || readAdrs[0] !== 12'hFFE || readAdrs[1] !== 12'hFFF || readAdrs[2] !== 12'h000) begin
      nFail++; $display("FAIL wrap_read_order: got %0d reads expected ffe,fff,000", readAdrs.size()); end
    nVec++; if (mem[12'h100] !== 16'hAAAA || mem[12'h101] !== 16'h5555 || mem[12'h102] !== 16'h1111) begin nFail++;
      $display("FAIL wrap_data: got %h %h %h expected aaaa 5555 1111", mem[12'h100], mem[12'h101], mem[12'h102]); end
    nVec++; if (checksum !== 16'h1110) begin nFail++; $display("FAIL wrap_checksum: got %h expected 1110", checksum); end
  endtask

  task automatic test_csum_wrap;
    poke(12'h300, 16'hFFFF); poke(12'h301, 16'h0002);
    do_copy(12'h300, 12'h400, 13'd2, 0);
    nVec++; if (checksum !== 16'h0001) begin nFail++; $display("FAIL csum_wrap: got %h expected 0001", checksum); end
    nVec++; if (mem[12'h401] !== 16'h0002) begin nFail++; $display("FAIL csum_wrap_data: got %h expected 0002", mem[12'h401]); end
  endtask

  task automatic test_rst_mid;
    int doneSeen;
    for (int k = 0; k < 8; k++) begin
      poke(12'h500 + 12'(k), 16'h1000 + 16'(k));
      poke(12'h600 + 12'(k), 16'hDEAD);
    end
    @(negedge clk);
    srcAdr = 12'h500; dstAdr = 12'h600; len = 13'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    nVec++; if (memRead !== 1'b1 || memAdr !== 12'h503) begin nFail++;
      $display("FAIL rst_mid_fourth_read: got rd=%b adr=%h expected 1/503", memRead, memAdr); end
    rst = 1'b1;
    @(negedge clk);
    nVec++; if ({busy, done, memRead, memWrite} !== 4'b0000 || memAdr !== 12'h0 || writeData !== 16'h0 || checksum !== 16'h0) begin
      nFail++; $display("FAIL rst_mid_outputs: got b/d/r/w=%b adr=%h wd=%h cs=%h expected all zero",
        {busy, done, memRead, memWrite}, memAdr, writeData, checksum); end
    rst = 1'b0;
    doneSeen = 0;
    repeat (4) begin @(negedge clk); if (done) doneSeen++; end
    nVec++; if (doneSeen != 0) begin nFail++; $display("FAIL rst_mid_no_done: got %0d done cycles expected 0", doneSeen); end
    for (int k = 0; k < 8; k++) begin
      nVec++;
      if (mem[12'h600 + 12'(k)] !== ((k < 3) ? 16'h1000 + 16'(k) : 16'hDEAD)) begin nFail++;
        $display("FAIL rst_mid_dst[%0d]: got %h expected %h", k, mem[12'h600 + 12'(k)],
          (k < 3) ? 16'h1000 + 16'(k) : 16'hDEAD); end
    end
    do_copy(12'h500, 12'h600, 13'd8, 0);
    nVec++; if (doneAt != 17 || checksum !== 16'h801C) begin nFail++;
      $display("FAIL rst_mid_restart: got doneAt=%0d cs=%h expected 17/801c", doneAt, checksum); end
    nVec++; if (mem[12'h607] !== 16'h1007) begin nFail++; $display("FAIL rst_mid_restart_data: got %h expected 1007", mem[12'h607]); end
  endtask

  task automatic test_start_ignored;
    poke(12'h700, 16'h0001); poke(12'h701, 16'h0002); poke(12'h702, 16'h0003);
    do_copy(12'h700, 12'h710, 13'd3, 2);
    nVec++; if (busyCnt != 6 || doneAt != 7) begin nFail++;
      $display("FAIL ignore_timing: got busy=%0d doneAt=%0d expected 6/7", busyCnt, doneAt); end
    nVec++; if (checksum !== 16'h0006) begin nFail++; $display("FAIL ignore_checksum: got %h expected 0006", checksum); end
    nVec++; if (mem[12'h710] !== 16'h1 || mem[12'h711] !== 16'h2 || mem[12'h712] !== 16'h3) begin nFail++;
      $display("FAIL ignore_data: got %h %h %h expected 0001 0002 0003", mem[12'h710], mem[12'h711], mem[12'h712]); end
    nVec++; if (mem[12'h000] !== 16'h1111) begin nFail++; $display("FAIL ignore_no_junk_copy: got %h expected 1111", mem[12'h000]); end
    nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++;
      $display("FAIL ignore_idle_after: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_csum_wrap();
    test_rst_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
`default_nettype wire
